fetch_stage: RTL and testbench



---
 rtl/fetch_pkg.sv | 29 ++
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/fetch_stage.sv | 193 +++++++++++++++++++
 tb/tb_fetch_stage.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the FSM state encoding, the default-width FIFO entry layout and the NOP constant.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (adds a fault bit to each FIFO entry).
package fetch_pkg;

    localparam int FETCH_ADDR_W  = 32;
    localparam int FETCH_INSTR_W = 32;

    localparam logic [FETCH_INSTR_W-1:0] NOP_INSTR = 32'h0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DROP  = 3'd3,
        GAP   = 3'd4
    } fetch_state_t;

    // Entry layout at the default widths; the fetch stage builds a
    // parameter-sized struct with the same field order.
    typedef struct packed {
        logic [FETCH_INSTR_W-1:0] instr;
        logic [FETCH_ADDR_W-1:0]  pc;
`ifdef FETCH_MISALIGN_CHECK_EN
        logic                     fault;
`endif
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with synchronous clear and occupancy count.
// Latency: a push is visible at the head one cycle later; head is read combinationally.
// Backpressure: push is ignored when full unless a pop frees the slot in the same cycle; clear beats push and pop.
// Ports: clk, reset (async active-low), clear, push/push_data, pop, head_data, empty, count.
module fetch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign do_pop    = pop & ~empty & ~clear;
    assign do_push   = push & ~clear & (~full | do_pop);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is only consumed while count is non-zero.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: samples pc, runs a req/ack read to imem, buffers {instr, pc} toward decode.
// Latency: ISSUE(t), earliest ack(t+1), out_valid(t+2); one request outstanding, one fetch per two cycles at best.
// Backpressure: issue is gated on a free FIFO slot so an ack always has room; out_ready pops the head.
// Ports: clk, reset (async active-low), pc/pc_advance/flush to the PC block, imem_req/addr/ack/rdata,
//        out_valid/out_ready/out_instr/out_pc toward decode, busy while a request is outstanding.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (adds out_fault; misaligned pc produces a fault entry).
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int ADDR_W    = FETCH_ADDR_W,
    parameter int INSTR_W   = FETCH_INSTR_W,
    parameter int BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc,
    output logic               pc_advance,
    input  logic               flush,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic               out_fault,
`endif
    output logic               busy
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
`ifdef FETCH_MISALIGN_CHECK_EN
        logic               fault;
`endif
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    fetch_state_t       state_q;
    fetch_state_t       state_d;
    logic [ADDR_W-1:0]  req_pc_q;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W-1:0]   count_after;
    logic               fifo_empty;
    logic               fifo_pop;
    logic               fifo_push;
    logic               slot_free;
    logic               slot_after;
    logic               ack_take;
    logic               misaligned;
    logic               fault_push;
    entry_t             push_entry;
    entry_t             head_entry;
    logic [ENTRY_W-1:0] head_bits;

    always_comb begin
        fifo_pop    = out_valid & out_ready;
        slot_free   = fifo_count < DEPTH_C;
        // Outstanding request implies a reserved slot, so count+1 cannot overflow.
        count_after = fifo_count + CNT_W'(1) - CNT_W'(fifo_pop);
        slot_after  = count_after < DEPTH_C;
        ack_take    = (state_q == WAIT) & imem_ack & ~flush;
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    logic fault_hold_q;

    assign misaligned = |pc[1:0];
    // A fault entry is pushed once; the stage then parks in IDLE until a redirect.
    assign fault_push = (state_q == IDLE) & ~flush & misaligned & ~fault_hold_q & slot_free;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fault_hold_q <= 1'b0;
        end else if (flush) begin
            fault_hold_q <= 1'b0;
        end else if (fault_push) begin
            fault_hold_q <= 1'b1;
        end
    end
`else
    assign misaligned = 1'b0;
    assign fault_push = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            req_pc_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ISSUE) req_pc_q <= pc;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (flush)                         state_d = GAP;
                else if (!misaligned && slot_free) state_d = ISSUE;
            end
            // The request is already on the bus; a redirect here must still drain its ack.
            ISSUE: state_d = flush ? DROP : WAIT;
            WAIT: begin
                if (imem_ack) begin
                    if (flush)           state_d = GAP;
                    else if (slot_after) state_d = ISSUE;
                    else                 state_d = IDLE;
                end else if (flush) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem_ack) state_d = GAP;
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        imem_req   = 1'b0;
        busy       = 1'b0;
        pc_advance = ack_take;
        imem_addr  = {req_pc_q[ADDR_W-1:2], 2'b00};
        unique case (state_q)
            ISSUE: begin
                imem_req  = 1'b1;
                busy      = 1'b1;
                imem_addr = {pc[ADDR_W-1:2], 2'b00};
            end
            WAIT, DROP: begin
                imem_req = 1'b1;
                busy     = 1'b1;
            end
            default: begin
                imem_req = 1'b0;
                busy     = 1'b0;
            end
        endcase
    end

    always_comb begin
        push_entry       = '0;
        push_entry.instr = imem_rdata;
        push_entry.pc    = req_pc_q;
`ifdef FETCH_MISALIGN_CHECK_EN
        if (fault_push) begin
            push_entry.instr = INSTR_W'(NOP_INSTR);
            push_entry.pc    = pc;
            push_entry.fault = 1'b1;
        end
`endif
    end

    assign fifo_push = ack_take | fault_push;

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head_data (head_bits),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign head_entry = entry_t'(head_bits);
    assign out_valid  = ~fifo_empty;
    assign out_instr  = out_valid ? head_entry.instr : '0;
    assign out_pc     = out_valid ? head_entry.pc    : '0;
`ifdef FETCH_MISALIGN_CHECK_EN
    assign out_fault  = out_valid & head_entry.fault;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations plus a long
// randomized run, all checked every cycle against a transaction-level model
// (outstanding request, FIFO as a queue, PC register stepping on pc_advance/flush).
module tb_fetch_stage;

    localparam int DEPTH = 2;
`ifdef FETCH_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc = '0;
    logic        pc_advance;
    logic        flush = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        busy;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        out_fault;
`endif

    always #5 clk = ~clk;

    fetch_stage #(.ADDR_W(32), .INSTR_W(32), .BUF_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .pc_advance (pc_advance),
        .flush      (flush),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
`ifdef FETCH_MISALIGN_CHECK_EN
        .out_fault  (out_fault),
`endif
        .busy       (busy)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // stimulus knobs
    int          lat_lo = 1, lat_hi = 1, ready_pct = 100, flush_pct = 0;
    bit          dir_flush = 0, force_ack = 0, rand_mis = 0;
    logic [31:0] dir_tgt = '0;
    logic [31:0] pc_nxt = '0;

    // memory responder
    int mem_cnt = 0, mem_lat = 1;

    // reference model: one optional outstanding request plus a queue of entries
    bit          m_active, m_first, m_doomed, m_gap, m_fhold;
    logic [31:0] m_req_pc;
    fetch_pkg::fetch_entry_t q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_first = 0; m_doomed = 0; m_gap = 0; m_fhold = 0;
        m_req_pc = '0;
        q.delete();
    endtask

    task automatic step(input bit rst_assert);
        bit          rq, e_adv, pop, push, slot_left;
        logic [31:0] e_addr, tgt;
        fetch_pkg::fetch_entry_t pe;
        @(negedge clk);
        pc    = pc_nxt;
        reset = !rst_assert;
        rq = !rst_assert && imem_req;
        if (!rq) mem_cnt = 0;
        else begin
            if (mem_cnt == 0) mem_lat = $urandom_range(lat_hi, lat_lo);
            mem_cnt++;
        end
        imem_ack = (rq && mem_cnt > mem_lat) || force_ack;
        if (imem_ack) mem_cnt = 0;
        imem_rdata = $urandom;
        out_ready  = ($urandom_range(99, 0) < ready_pct);
        flush = 1'b0;
        if (!rst_assert) begin
            if (dir_flush) flush = 1'b1;
            else if (!(m_active && m_first) && $urandom_range(99, 0) < flush_pct) flush = 1'b1;
        end
        tgt = dir_flush ? dir_tgt : ($urandom & 32'h0000_0ffc);
        if (!dir_flush && rand_mis && $urandom_range(7, 0) == 0) tgt[1:0] = 2'($urandom_range(3, 1));
        #1;
        if (rst_assert) begin
            chk("rst_req", imem_req, 0);
            chk("rst_addr", imem_addr, 0);
            chk("rst_adv", pc_advance, 0);
            chk("rst_valid", out_valid, 0);
            chk("rst_instr", out_instr, 0);
            chk("rst_pc", out_pc, 0);
            chk("rst_busy", busy, 0);
`ifdef FETCH_MISALIGN_CHECK_EN
            chk("rst_fault", out_fault, 0);
`endif
            model_reset();
            cyc = 0;
            return;
        end
        // expected outputs for this cycle
        e_addr = m_first ? {pc[31:2], 2'b00} : {m_req_pc[31:2], 2'b00};
        e_adv  = m_active && !m_first && !m_doomed && imem_ack && !flush;
        chk("imem_req", imem_req, m_active);
        chk("busy", busy, m_active);
        if (m_active) chk("imem_addr", imem_addr, e_addr);
        chk("pc_advance", pc_advance, e_adv);
        chk("out_valid", out_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("out_instr", out_instr, q[0].instr);
            chk("out_pc", out_pc, q[0].pc);
`ifdef FETCH_MISALIGN_CHECK_EN
            chk("out_fault", out_fault, q[0].fault);
`endif
        end
        // advance the model by one clock edge
        pop  = out_ready && q.size() > 0;
        push = 0;
        pe   = '0;
        if (!m_active) begin
            if (m_gap) m_gap = 0;
            else if (flush) m_gap = 1;
            else if (MIS_EN && pc[1:0] != 2'b00) begin
                if (!m_fhold && q.size() < DEPTH) begin
                    push = 1; pe.instr = 32'h0; pe.pc = pc;
`ifdef FETCH_MISALIGN_CHECK_EN
                    pe.fault = 1'b1;
`endif
                    m_fhold = 1;
                end
            end else if (q.size() < DEPTH) begin
                m_active = 1; m_first = 1;
            end
        end else if (m_first) begin
            m_first  = 0;
            m_req_pc = pc;
        end else if (imem_ack) begin
            m_active = 0;
            if (m_doomed || flush) begin
                m_gap = 1; m_doomed = 0;
            end else begin
                push = 1; pe.instr = imem_rdata; pe.pc = m_req_pc;
                slot_left = (q.size() + 1 - (pop ? 1 : 0)) < DEPTH;
                if (slot_left) begin m_active = 1; m_first = 1; end
            end
        end else if (flush) m_doomed = 1;
        if (flush) m_fhold = 0;
        if (flush) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(pe);
        end
        // PC register outside the DUT
        pc_nxt = pc;
        if (flush) pc_nxt = tgt;
        else if (e_adv) pc_nxt = pc + 32'd4;
        cyc++;
    endtask

    task automatic restart(input logic [31:0] start_pc, input int lat, input int rdy);
        pc_nxt = start_pc; lat_lo = lat; lat_hi = lat; ready_pct = rdy;
        flush_pct = 0; dir_flush = 0; force_ack = 0; rand_mis = 0;
        step(1);
        step(1);
    endtask

    initial begin
        logic [31:0] d;
        int          n;
        model_reset();

        // basic fetch, 1-cycle ack
        restart(32'h0, 1, 100);
        d = '0;
        for (int k = 0; k < 6; k++) begin
            step(0);
            if (k == 1) begin chk("t1_req", imem_req, 1); chk("t1_addr", imem_addr, 32'h0); end
            if (k == 2) begin chk("t1_adv", pc_advance, 1); d = imem_rdata; end
            if (k == 3) begin
                chk("t1_valid", out_valid, 1); chk("t1_pc", out_pc, 32'h0); chk("t1_instr", out_instr, d);
            end
        end

        // decode stalled: FIFO fills, third fetch waits for a pop
        restart(32'h0, 1, 0);
        for (int k = 0; k < 12; k++) begin
            ready_pct = (k == 9) ? 100 : 0;
            step(0);
            if (k == 8)  begin chk("t2_noreq", imem_req, 0); chk("t2_valid", out_valid, 1); chk("t2_head", out_pc, 32'h0); end
            if (k == 10) chk("t2_head2", out_pc, 32'h4);
            if (k == 11) begin chk("t2_req8", imem_req, 1); chk("t2_addr8", imem_addr, 32'h8); end
        end

        // slow memory: request held stable, one advance
        restart(32'h0, 5, 100);
        n = 0;
        for (int k = 0; k < 8; k++) begin
            step(0);
            if (pc_advance) n++;
            if (k >= 2 && k <= 5) begin chk("t3_req_hold", imem_req, 1); chk("t3_addr_hold", imem_addr, 32'h0); end
            if (k == 6) chk("t3_adv", pc_advance, 1);
        end
        chk("t3_adv_count", n, 1);

        // flush during WAIT: in-flight response dropped, redirect fetched after GAP
        restart(32'h0, 6, 100);
        dir_tgt = 32'h40;
        for (int k = 0; k < 12; k++) begin
            dir_flush = (k == 3);
            step(0);
            if (k == 7)  chk("t4_no_adv", pc_advance, 0);
            if (k == 8)  chk("t4_gap", imem_req, 0);
            if (k == 10) begin chk("t4_req", imem_req, 1); chk("t4_addr", imem_addr, 32'h40); end
            if (k == 11) chk("t4_empty", out_valid, 0);
        end
        dir_flush = 0;

        // flush coinciding with ack
        restart(32'h0, 2, 100);
        dir_tgt = 32'h80;
        for (int k = 0; k < 8; k++) begin
            dir_flush = (k == 3);
            step(0);
            if (k == 3) begin chk("t5_ack", imem_ack, 1); chk("t5_no_adv", pc_advance, 0); end
            if (k == 4) chk("t5_empty", out_valid, 0);
            if (k == 6) begin chk("t5_req", imem_req, 1); chk("t5_addr", imem_addr, 32'h80); end
        end
        dir_flush = 0;

        // reset while waiting, then a stale ack
        restart(32'h0, 1, 0);
        for (int k = 0; k < 5; k++) begin
            if (k == 3) begin lat_lo = 10; lat_hi = 10; end
            step(0);
            if (k == 4) begin chk("t6_pre_valid", out_valid, 1); chk("t6_pre_busy", busy, 1); end
        end
        step(1);
        force_ack = 1;
        step(0);
        chk("t6_late_adv", pc_advance, 0);
        force_ack = 0;
        step(0);
        step(0);
        chk("t6_late_nopush", out_valid, 0);

`ifdef FETCH_MISALIGN_CHECK_EN
        restart(32'h6, 1, 0);
        for (int k = 0; k < 4; k++) begin
            step(0);
            if (k == 1) begin
                chk("t7_req", imem_req, 0); chk("t7_valid", out_valid, 1); chk("t7_fault", out_fault, 1);
                chk("t7_instr", out_instr, 0); chk("t7_pc", out_pc, 32'h6);
            end
        end
`endif

        // randomized traffic with flushes, stalls, misaligned targets and resets
        restart(32'h100, 1, 60);
        lat_lo = 1; lat_hi = 4; flush_pct = 6; rand_mis = 1;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(499, 0) == 0) step(1);
            else step(0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
